// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter: the IF requester, the MEM requester,
// the external memory bus, the pipeline stall and the error flag.
//
// Handshake semantics (all rising-edge synchronous):
//   - Requester side: if_req / mem_rd / mem_wr act as "valid" and are held,
//     with stable address/data, until the matching one-cycle ack. The ack
//     cycle is the only cycle in which if_rdata / mem_rdata is guaranteed new.
//   - Bus side: bus_req acts as "valid" and bus_ready as "ready"; a transfer
//     completes on an edge where both are 1. bus_* outputs are stable while
//     bus_req=1 and bus_ready=0. bus_ready is ignored while bus_req=0.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
);
  // instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  // data access requester
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  // external memory bus
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [BE_W-1:0]   bus_be;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ready;
  // pipeline status
  logic              stall;
  logic              err_rdwr;

  // arbiter view
  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_be,
    input  bus_rdata, bus_ready,
    output if_rdata, if_ack, mem_rdata, mem_ack,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output stall, err_rdwr
  );

  // pipeline + memory view
  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_be,
    output bus_rdata, bus_ready,
    input  if_rdata, if_ack, mem_rdata, mem_ack,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  stall, err_rdwr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction
// fetch and data access. One bus transaction at a time, arbitrary bus wait
// states, one-cycle ack with registered read data, combinational stall.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on ties instead
// of fixed data-first priority.
// dbg_state exposes the FSM state (0 IDLE, 1 BUS_D, 2 BUS_I, 3 DONE).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  port,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_D = 2'd1,
    BUS_I = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [BE_W-1:0]   bus_be_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_ack_q;
  logic              mem_ack_q;
  logic              err_rdwr_q;

  logic data_pend;
  logic grant_d;
  logic grant_i;
  logic bus_done;

  assign data_pend = port.mem_rd | port.mem_wr;
  // bus_ready only counts while a transfer is actually on the bus
  assign bus_done  = bus_req_q & port.bus_ready;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_d = 1 when data was the most recent grant; reset says "data", so
  // fetch wins the first tie.
  logic last_d;

  assign grant_d = data_pend & (~port.if_req | ~last_d);

  // remember who was served last on every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b1;
    end else if ((state == IDLE) && (data_pend || port.if_req)) begin
      last_d <= grant_d;
    end
  end
`else
  // data access always wins a tie
  assign grant_d = data_pend;
`endif

  assign grant_i = port.if_req & ~grant_d;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: grant only from IDLE, hold until the bus completes, one ack cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = BUS_D;
        end else if (grant_i) begin
          state_nxt = BUS_I;
        end
      end
      BUS_D, BUS_I: begin
        if (bus_done) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bus registers, read-data capture and one-cycle ack pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            // simultaneous rd+wr is resolved as a write
            bus_req_q   <= 1'b1;
            bus_we_q    <= port.mem_wr;
            bus_addr_q  <= port.mem_addr;
            bus_wdata_q <= port.mem_wdata;
            bus_be_q    <= port.mem_wr ? port.mem_be : '1;
          end else if (grant_i) begin
            bus_req_q  <= 1'b1;
            bus_we_q   <= 1'b0;
            bus_addr_q <= port.if_addr;
            bus_be_q   <= '1;
          end
        end
        BUS_D: begin
          if (bus_done) begin
            bus_req_q <= 1'b0;
            mem_ack_q <= 1'b1;
            if (!bus_we_q) begin
              mem_rdata_q <= port.bus_rdata;
            end
          end
        end
        BUS_I: begin
          if (bus_done) begin
            bus_req_q  <= 1'b0;
            if_ack_q   <= 1'b1;
            if_rdata_q <= port.bus_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // sticky decode error: read and write requested together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_rdwr_q <= 1'b0;
    end else if (port.mem_rd && port.mem_wr) begin
      err_rdwr_q <= 1'b1;
    end
  end

  assign port.bus_req   = bus_req_q;
  assign port.bus_we    = bus_we_q;
  assign port.bus_addr  = bus_addr_q;
  assign port.bus_wdata = bus_wdata_q;
  assign port.bus_be    = bus_be_q;
  assign port.if_rdata  = if_rdata_q;
  assign port.if_ack    = if_ack_q;
  assign port.mem_rdata = mem_rdata_q;
  assign port.mem_ack   = mem_ack_q;
  assign port.err_rdwr  = err_rdwr_q;
  assign port.stall     = (data_pend & ~mem_ack_q) | (port.if_req & ~if_ack_q);
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: reset state, a table of single
// transactions, collision / hold / reset-mid-transfer sequences, randomized
// traffic against a transaction-level model, and the rd+wr error flag.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bif ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .port      (bif),
    .dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bif.if_req    = 1'b0;
    bif.if_addr   = '0;
    bif.mem_rd    = 1'b0;
    bif.mem_wr    = 1'b0;
    bif.mem_addr  = '0;
    bif.mem_wdata = '0;
    bif.mem_be    = '0;
    bif.bus_rdata = '0;
    bif.bus_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        i_req;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    logic        e_we;
    logic [3:0]  e_be;
    logic        e_ack_i;
    int          e_lat;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[6];
  logic m_err = 1'b0;

  // one transaction with the bench acting as bus slave
  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    int bus_cyc;
    bit got;
    @(negedge clk);
    bif.if_req    = v.i_req;
    bif.if_addr   = v.addr;
    bif.mem_rd    = v.d_rd;
    bif.mem_wr    = v.d_wr;
    bif.mem_addr  = v.addr;
    bif.mem_wdata = v.wdata;
    bif.mem_be    = v.be;
    bif.bus_ready = 1'b0;
    bif.bus_rdata = v.rdata;
    cyc = 0;
    bus_cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bif.if_ack || bif.mem_ack) begin
        got = 1'b1;
        chk($sformatf("v%0d_ack_latency", idx), cyc, v.e_lat);
        chk($sformatf("v%0d_if_ack", idx), bif.if_ack, v.e_ack_i);
        chk($sformatf("v%0d_mem_ack", idx), bif.mem_ack, !v.e_ack_i);
        chk($sformatf("v%0d_rdata", idx), v.e_ack_i ? bif.if_rdata : bif.mem_rdata, v.e_rdata);
        chk($sformatf("v%0d_bus_req_at_ack", idx), bif.bus_req, 1'b0);
        chk($sformatf("v%0d_stall_at_ack", idx), bif.stall, 1'b0);
      end else begin
        chk($sformatf("v%0d_stall_wait", idx), bif.stall, 1'b1);
        if (bif.bus_req) begin
          bus_cyc++;
          chk($sformatf("v%0d_bus_we", idx), bif.bus_we, v.e_we);
          chk($sformatf("v%0d_bus_addr", idx), bif.bus_addr, v.addr);
          chk($sformatf("v%0d_bus_be", idx), bif.bus_be, v.e_be);
          if (v.e_we) chk($sformatf("v%0d_bus_wdata", idx), bif.bus_wdata, v.wdata);
          bif.bus_ready = (bus_cyc > v.waits);
        end else begin
          bif.bus_ready = 1'b0;
        end
      end
    end
    chk($sformatf("v%0d_ack_seen", idx), got, 1'b1);
    chk($sformatf("v%0d_bus_cycles", idx), bus_cyc, v.waits + 1);
    idle_inputs();
    @(negedge clk);
    chk($sformatf("v%0d_stall_after", idx), bif.stall, 1'b0);
    chk($sformatf("v%0d_ack_cleared", idx), bif.if_ack | bif.mem_ack, 1'b0);
    chk($sformatf("v%0d_rdata_hold", idx), v.e_ack_i ? bif.if_rdata : bif.mem_rdata, v.e_rdata);
    chk($sformatf("v%0d_err_rdwr", idx), bif.err_rdwr, m_err);
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic        d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        td, ti, cur;
  logic [31:0] m_if_rdata, m_mem_rdata, due_rdata;
  bit          m_last_d, want_d, want_i, first_d, pend_d, pend_i;
  bit          in_flight, due_i, due_d, due_we, exp_ai, exp_ad, done;
  int unsigned sel;
  int          waits, seen;
  logic [3:0]  drv_be;

  // collision / hold bookkeeping
  int  mem_c, if_c, nack, last_c;
  bit  first_seen;

  initial begin
    rst = 1'b1;
    idle_inputs();

    //                i  rd wr addr          wdata         be    w  rdata         we be    ackI lat e_rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0050_0093, 1'b0, 4'hF, 1'b1, 2, 32'h0050_0093};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 3, 32'h1234_5678, 1'b1, 4'h3, 1'b0, 5, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'h1, 1, 32'hCAFE_F00D, 1'b0, 4'hF, 1'b0, 3, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h1122_3344, 4'h8, 0, 32'hFFFF_FFFF, 1'b1, 4'h8, 1'b0, 2, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 2, 32'hFE01_0113, 1'b0, 4'hF, 1'b1, 4, 32'hFE01_0113};
    // rd+wr together: treated as a write, mem_rdata untouched (0 after reset)
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_5000, 32'h0BAD_F00D, 4'h6, 0, 32'h7777_7777, 1'b1, 4'h6, 1'b0, 2, 32'h0};

    // ---- reset state ----
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bus_req", bif.bus_req, 1'b0);
    chk("rst_bus_we", bif.bus_we, 1'b0);
    chk("rst_bus_addr", bif.bus_addr, 32'h0);
    chk("rst_bus_wdata", bif.bus_wdata, 32'h0);
    chk("rst_bus_be", bif.bus_be, 4'h0);
    chk("rst_if_ack", bif.if_ack, 1'b0);
    chk("rst_mem_ack", bif.mem_ack, 1'b0);
    chk("rst_if_rdata", bif.if_rdata, 32'h0);
    chk("rst_mem_rdata", bif.mem_rdata, 32'h0);
    chk("rst_err_rdwr", bif.err_rdwr, 1'b0);
    chk("rst_stall", bif.stall, 1'b0);
    chk("rst_state", dbg_state, 2'd0);

    // ---- table of single transactions ----
    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // ---- collision, requests dropped after their own ack ----
    do_reset();
    @(negedge clk);
    bif.if_req    = 1'b1;
    bif.if_addr   = 32'h0000_0200;
    bif.mem_rd    = 1'b1;
    bif.mem_addr  = 32'h0000_0400;
    bif.bus_ready = 1'b1;
    bif.bus_rdata = 32'h1357_2468;
    mem_c = -1;
    if_c = -1;
    first_seen = 1'b0;
    for (int c = 1; c <= 30 && (mem_c < 0 || if_c < 0); c++) begin
      @(negedge clk);
      if (bif.bus_req && !first_seen) begin
        first_seen = 1'b1;
        chk("col_first_addr", bif.bus_addr, RR_EN ? 32'h0000_0200 : 32'h0000_0400);
      end
      if (bif.mem_ack) begin mem_c = c; bif.mem_rd = 1'b0; end
      if (bif.if_ack)  begin if_c = c;  bif.if_req = 1'b0; end
    end
    chk("col_mem_acked", mem_c >= 0, 1'b1);
    chk("col_if_acked", if_c >= 0, 1'b1);
    chk("col_first_latency", RR_EN ? if_c : mem_c, 2);
    chk("col_ack_spacing", RR_EN ? (mem_c - if_c) : (if_c - mem_c), 3);
    idle_inputs();

    // ---- both requesters held for four transactions ----
    do_reset();
    @(negedge clk);
    bif.if_req    = 1'b1;
    bif.if_addr   = 32'h0000_0300;
    bif.mem_rd    = 1'b1;
    bif.mem_addr  = 32'h0000_0700;
    bif.bus_ready = 1'b1;
    bif.bus_rdata = 32'h0F0F_0F0F;
    nack = 0;
    last_c = 0;
    for (int c = 1; c <= 40 && nack < 4; c++) begin
      @(negedge clk);
      if (bif.if_ack || bif.mem_ack) begin
        chk($sformatf("hold_who_%0d", nack), bif.mem_ack, RR_EN ? (nack % 2 == 1) : 1'b1);
        chk($sformatf("hold_spacing_%0d", nack), c - last_c, (nack == 0) ? 2 : 3);
        last_c = c;
        nack++;
      end
    end
    chk("hold_count", nack, 4);
    idle_inputs();

    // ---- reset while a store waits on the bus ----
    @(negedge clk);
    @(negedge clk);
    bif.mem_wr    = 1'b1;
    bif.mem_addr  = 32'h0000_6000;
    bif.mem_wdata = 32'h55AA_55AA;
    bif.mem_be    = 4'hF;
    bif.bus_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmid_bus_req_before", bif.bus_req, 1'b1);
    chk("rmid_state_before", dbg_state, 2'd1);
    rst = 1'b1;
    bif.bus_ready = 1'b1;
    #1;
    chk("rmid_bus_req", bif.bus_req, 1'b0);
    chk("rmid_mem_ack", bif.mem_ack, 1'b0);
    chk("rmid_state", dbg_state, 2'd0);
    chk("rmid_bus_addr", bif.bus_addr, 32'h0);
    idle_inputs();
    @(negedge clk);
    chk("rmid_mem_ack_in_rst", bif.mem_ack, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_mem_ack_after", bif.mem_ack, 1'b0);
    chk("rmid_state_after", dbg_state, 2'd0);
    run_vec(10, vecs[0]);

    // ---- randomized traffic against the transaction model ----
    do_reset();
    m_if_rdata  = '0;
    m_mem_rdata = '0;
    m_last_d    = 1'b1;
    due_i = 1'b0; due_d = 1'b0; due_we = 1'b0; due_rdata = '0;
    in_flight = 1'b0;
    waits = 0;
    seen = 0;
    for (int it = 0; it < 80; it++) begin
      sel    = $urandom_range(1, 3);
      want_d = sel[0];
      want_i = sel[1];
      drv_be = 4'($urandom_range(1, 15));
      td.d     = 1'b1;
      td.we    = 1'($urandom_range(0, 1));
      td.addr  = $urandom & 32'hFFFF_FFFC;
      td.wdata = $urandom;
      td.be    = td.we ? drv_be : 4'hF;
      ti.d     = 1'b0;
      ti.we    = 1'b0;
      ti.addr  = $urandom & 32'hFFFF_FFFC;
      ti.wdata = '0;
      ti.be    = 4'hF;
      // grant order: tie goes to data, or to whoever was not served last
      first_d = want_d && (!want_i || !RR_EN || !m_last_d);
      if (first_d) begin
        exp_q.push_back(td);
        if (want_i) exp_q.push_back(ti);
      end else begin
        exp_q.push_back(ti);
        if (want_d) exp_q.push_back(td);
      end
      m_last_d = (want_d && want_i) ? !first_d : want_d;
      bif.mem_rd    = want_d & ~td.we;
      bif.mem_wr    = want_d & td.we;
      bif.mem_addr  = td.addr;
      bif.mem_wdata = td.wdata;
      bif.mem_be    = drv_be;
      bif.if_req    = want_i;
      bif.if_addr   = ti.addr;
      pend_d = want_d;
      pend_i = want_i;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        exp_ai = due_i;
        exp_ad = due_d;
        due_i = 1'b0;
        due_d = 1'b0;
        if (exp_ai) m_if_rdata = due_rdata;
        if (exp_ad && !due_we) m_mem_rdata = due_rdata;
        chk("rnd_if_ack", bif.if_ack, exp_ai);
        chk("rnd_mem_ack", bif.mem_ack, exp_ad);
        chk("rnd_if_rdata", bif.if_rdata, m_if_rdata);
        chk("rnd_mem_rdata", bif.mem_rdata, m_mem_rdata);
        chk("rnd_stall", bif.stall, (pend_d && !exp_ad) || (pend_i && !exp_ai));
        chk("rnd_err_rdwr", bif.err_rdwr, 1'b0);
        if (exp_ai) begin pend_i = 1'b0; bif.if_req = 1'b0; end
        if (exp_ad) begin pend_d = 1'b0; bif.mem_rd = 1'b0; bif.mem_wr = 1'b0; end
        if (in_flight) chk("rnd_bus_req_held", bif.bus_req, 1'b1);
        if (bif.bus_req) begin
          if (!in_flight) begin
            chk("rnd_txn_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              in_flight = 1'b1;
              waits = $urandom_range(0, 3);
              seen = 0;
            end
          end
          if (in_flight) begin
            chk("rnd_bus_we", bif.bus_we, cur.we);
            chk("rnd_bus_addr", bif.bus_addr, cur.addr);
            chk("rnd_bus_be", bif.bus_be, cur.be);
            if (cur.we) chk("rnd_bus_wdata", bif.bus_wdata, cur.wdata);
            seen++;
            if (seen > waits) begin
              bif.bus_ready = 1'b1;
              bif.bus_rdata = $urandom;
              due_i = !cur.d;
              due_d = cur.d;
              due_we = cur.we;
              due_rdata = bif.bus_rdata;
              in_flight = 1'b0;
            end else begin
              bif.bus_ready = 1'b0;
            end
          end
        end else begin
          // bus_ready with no transfer on the bus must be ignored
          bif.bus_ready = 1'($urandom_range(0, 1));
          bif.bus_rdata = $urandom;
        end
        done = !pend_d && !pend_i && !in_flight && !due_i && !due_d && (exp_q.size() == 0);
      end
      chk("rnd_iteration_done", done, 1'b1);
    end
    idle_inputs();

    // ---- rd+wr together: write, sticky error until reset ----
    do_reset();
    m_err = 1'b1;
    run_vec(5, vecs[5]);
    run_vec(11, vecs[0]);
    chk("err_sticky", bif.err_rdwr, 1'b1);
    do_reset();
    m_err = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_rst", bif.err_rdwr, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between instruction fetch (IF) and data access (MEM) in the RV32I pipeline.
- Sequences one bus transaction at a time and supports multi-cycle bus latency.
- Returns a one-cycle acknowledge with registered read data to each requester.
- Drives a pipeline stall while a requester is waiting for the port.

Parameters:
- ADDR_W, 32, address width of both requesters and the bus.
- DATA_W, 32, data width. Must be a multiple of 8.
- BE_W, DATA_W/8, byte-enable width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF requests an instruction read; held until if_ack.
- if_addr  in  ADDR_W  fetch address (the PC).
- if_rdata  out  DATA_W  fetched instruction; valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- mem_rd  in  1  data read request from the control decode (loads); held until mem_ack.
- mem_wr  in  1  data write request (stores); held until mem_ack.
- mem_addr  in  ADDR_W  data address (ALU result).
- mem_wdata  in  DATA_W  store data.
- mem_be  in  BE_W  store byte enables.
- mem_rdata  out  DATA_W  load data; valid while mem_ack=1.
- mem_ack  out  1  one-cycle data completion pulse.
- bus_req  out  1  bus transaction active.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_be  out  BE_W  bus byte enables; all ones on reads.
- bus_rdata  in  DATA_W  bus read data; sampled when bus_ready=1.
- bus_ready  in  1  bus completes the current transaction this cycle.
- stall  out  1  pipeline stall request.
- err_rdwr  out  1  sticky flag: mem_rd and mem_wr were seen high together.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = DATA.
- States:
  - IDLE: no transaction.
  - BUS_D: data transaction in flight.
  - BUS_I: fetch transaction in flight.
  - DONE: ack cycle.
- IDLE grant rules:
  - If mem_rd or mem_wr is high: latch address, data, byte enables and direction into the bus registers, assert bus_req next cycle, go to BUS_D.
  - Else if if_req is high: latch if_addr, bus_we=0, bus_be all ones, go to BUS_I.
  - Priority when both are pending is set by the arbitration policy (see Optional Feature).
- BUS_D / BUS_I: bus_* outputs stay constant until a cycle with bus_req=1 and bus_ready=1. On that edge:
  - bus_req drops to 0.
  - bus_rdata is captured into the granted requester's rdata register (reads only).
  - The granted ack is set for exactly one cycle. State goes to DONE.
- DONE: ack high and rdata valid. The next edge returns to IDLE. No grant is made in DONE; this gives the requester one cycle to deassert or change its request.
- Latency: request in cycle N → bus_req in cycle N+1 → with bus_ready in N+1, ack in N+2. Each bus wait cycle adds one cycle. Back-to-back transactions issue every 3 cycles at minimum.
- Reads: mem_rdata and if_rdata hold their last captured value after ack. Writes leave mem_rdata unchanged.
- mem_rd and mem_wr both high: treated as a write, and err_rdwr is set. err_rdwr clears only on rst.
- stall (combinational) = (mem_rd|mem_wr) & ~mem_ack | if_req & ~if_ack.
- A requester that deasserts its request before ack: the in-flight bus transaction still completes, the ack pulse is still issued, and the ack is ignored upstream.
- Request inputs are sampled only in IDLE. Changes on the request inputs during BUS_x or DONE do not affect the current transaction.
- bus_ready while bus_req=0 is ignored.
- Reset asserted mid-transaction: outputs go to 0 immediately, the in-flight transaction is abandoned, and no ack is issued.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are pending in IDLE, the grant goes to the requester not served last.
  - The pointer updates on each grant. Reset value DATA, so IF wins the first tie.
- Undefined: fixed priority; data always wins ties and the pointer logic is absent.
- In both cases a single pending requester is granted immediately.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, bus_ready=1 in the first bus_req cycle, bus_rdata=0x00500093 → bus_addr=0x100, bus_we=0, bus_be=0xF; if_ack=1 with if_rdata=0x00500093 two cycles after the request; stall=0 after the ack.
- Store with waits: mem_wr=1, mem_addr=0x2000, mem_wdata=0xDEADBEEF, mem_be=0x3, bus_ready held low for 3 cycles → bus outputs stable for 4 cycles with bus_we=1 and bus_be=0x3; mem_ack for one cycle; stall high until mem_ack.
- Collision, fixed priority: if_req and mem_rd high in the same cycle, held → data transaction first, then fetch; the two acks are 3 cycles apart when bus_ready is always 1.
- Collision with MEM_ARB_ROUND_ROBIN_EN, both held for 4 transactions → grant order IF, D, IF, D.
- Reset mid-operation: rst pulsed while in BUS_D with bus_ready=0 → bus_req=0 and mem_ack=0 immediately; after release, state is IDLE and a new request is granted normally.
- Illegal decode: mem_rd=1 and mem_wr=1 → bus_we=1 and err_rdwr=1; err_rdwr stays set until rst.
